// File: rtl/wb_arbiter_pkg.sv
// Types shared by the writeback arbiter and its LSU result queue.
//   wb_entry_t : one pending register write {hart_id, rd, wdata}
//   wb_sel_e   : which source wins the writeback port in a cycle
`include "defines.vh"

package wb_arbiter_pkg;

   typedef struct packed {
      logic [`HART_ID_W-1:0]  hart_id;
      logic [`REG_ADDR_W-1:0] rd;
      logic [`XLEN-1:0]       wdata;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_ALU  = 2'd1,
      SEL_LSU  = 2'd2
   } wb_sel_e;

   localparam int unsigned NUM_REGS = 2 ** `REG_ADDR_W;

   // x0 is hardwired zero, so a result targeting it is consumed but never written.
   function automatic logic writes_reg(input wb_entry_t e);
      return e.rd != '0;
   endfunction

endpackage

// File: rtl/defines.vh
// Shared widths for the register-file writeback path.
//   HART_NUM   - number of hardware threads
//   HART_ID_W  - width of a hart identifier
//   REG_ADDR_W - width of an architectural register address
//   XLEN       - register data width
`ifndef DEFINES_VH
`define DEFINES_VH
`define HART_NUM   2
`define HART_ID_W  1
`define REG_ADDR_W 5
`define XLEN       32
`endif

// File: rtl/wb_fifo2.sv
// Two-entry FIFO holding LSU results waiting for the writeback port.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (empties the queue)
//   push        - write push_data (ignored when full or in reset)
//   push_data   - entry to enqueue
//   pop         - discard the head entry (ignored when empty or in reset)
//   head        - oldest entry, valid only while count != 0
//   count       - number of stored entries (0..2)
`include "defines.vh"

module wb_fifo2
   import wb_arbiter_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  wb_entry_t push_data,
   input  logic      pop,
   output wb_entry_t head,
   output logic [1:0] count
);

   wb_entry_t  mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count_q;
   logic       do_push;
   logic       do_pop;

   assign do_push = rst_n && push && (count_q != 2'd2);
   assign do_pop  = rst_n && pop  && (count_q != 2'd0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage is not reset; count == 0 already marks it as empty, and
   // leaving data unreset keeps it plain flops without a reset mux.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign head  = mem[rd_ptr];
   assign count = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter between a single-cycle ALU result and a
// queued LSU/long-latency result, plus a per-hart pending-register scoreboard.
// Ports:
//   clk, rst_n                       - clock, synchronous active-low reset
//   alu_valid/ready/hart_id/rd/wdata - ALU result handshake (ready low while
//                                      the LSU queue is being forced through)
//   lsu_valid/ready/hart_id/rd/wdata - LSU result handshake into a 2-deep queue
//   iss_en/hart_id/rd                - mark a register pending on long-latency issue
//   chk_hart_id/rs1/rs2, busy_rs1/2  - combinational pending lookup for hazards
//   w_en/w_hart_id/waddr/wdata       - registered register-file write port
`include "defines.vh"

module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   alu_valid,
   output logic                   alu_ready,
   input  logic [`HART_ID_W-1:0]  alu_hart_id,
   input  logic [`REG_ADDR_W-1:0] alu_rd,
   input  logic [`XLEN-1:0]       alu_wdata,
   input  logic                   lsu_valid,
   output logic                   lsu_ready,
   input  logic [`HART_ID_W-1:0]  lsu_hart_id,
   input  logic [`REG_ADDR_W-1:0] lsu_rd,
   input  logic [`XLEN-1:0]       lsu_wdata,
   input  logic                   iss_en,
   input  logic [`HART_ID_W-1:0]  iss_hart_id,
   input  logic [`REG_ADDR_W-1:0] iss_rd,
   input  logic [`HART_ID_W-1:0]  chk_hart_id,
   input  logic [`REG_ADDR_W-1:0] chk_rs1,
   input  logic [`REG_ADDR_W-1:0] chk_rs2,
   output logic                   busy_rs1,
   output logic                   busy_rs2,
   output logic                   w_en,
   output logic [`HART_ID_W-1:0]  w_hart_id,
   output logic [`REG_ADDR_W-1:0] waddr,
   output logic [`XLEN-1:0]       wdata
);

   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   wb_entry_t          alu_entry;
   wb_entry_t          lsu_entry;
   wb_entry_t          q_head;
   wb_entry_t          sel_entry;
   wb_sel_e            sel;
   logic [1:0]         q_count;
   logic               q_empty;
   logic               q_push;
   logic               q_pop;
   logic               force_lsu;
   logic [CNT_W-1:0]   starve_q;
   logic [NUM_REGS-1:0] pending     [`HART_NUM];
   logic [NUM_REGS-1:0] pending_nxt [`HART_NUM];

   assign alu_entry = '{hart_id: alu_hart_id, rd: alu_rd, wdata: alu_wdata};
   assign lsu_entry = '{hart_id: lsu_hart_id, rd: lsu_rd, wdata: lsu_wdata};

   // ---------------- LSU result queue ----------------
   assign q_empty   = (q_count == 2'd0);
   assign lsu_ready = rst_n && (q_count != 2'd2);
   assign q_push    = lsu_valid && lsu_ready;
   assign q_pop     = (sel == SEL_LSU);

   wb_fifo2 u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (q_push),
      .push_data (lsu_entry),
      .pop       (q_pop),
      .head      (q_head),
      .count     (q_count)
   );

   // ---------------- arbitration ----------------
   // Once the queue head has lost STARVE_MAX cycles in a row, the ALU is
   // back-pressured for one cycle so the head is guaranteed to drain.
   assign force_lsu = (starve_q == STARVE_LIM);
   assign alu_ready = rst_n && !force_lsu;

   // NOTE: every combinational output gets a default first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      sel = SEL_NONE;
      if (rst_n) begin
         if (force_lsu && !q_empty)      sel = SEL_LSU;
         else if (alu_valid && alu_ready) sel = SEL_ALU;
         else if (!q_empty)              sel = SEL_LSU;
      end
   end

   always_comb begin
      sel_entry = '0;
      case (sel)
         SEL_ALU: sel_entry = alu_entry;
         SEL_LSU: sel_entry = q_head;
         default: sel_entry = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_q <= '0;
      end else if (q_empty || q_pop) begin
         starve_q <= '0;
      end else if (starve_q != STARVE_LIM) begin
         starve_q <= starve_q + CNT_W'(1);
      end
   end

   // ---------------- registered write port ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_en      <= 1'b0;
         w_hart_id <= '0;
         waddr     <= '0;
         wdata     <= '0;
      end else begin
         w_en      <= (sel != SEL_NONE) && writes_reg(sel_entry);
         w_hart_id <= sel_entry.hart_id;
         waddr     <= sel_entry.rd;
         wdata     <= sel_entry.wdata;
      end
   end

   // ---------------- pending-register scoreboard ----------------
   // The clear is applied before the set so an issue to the same register
   // in the cycle its previous result retires keeps it pending.
   always_comb begin
      pending_nxt = pending;
      if (q_pop && writes_reg(q_head))
         pending_nxt[q_head.hart_id][q_head.rd] = 1'b0;
      if (rst_n && iss_en && (iss_rd != '0))
         pending_nxt[iss_hart_id][iss_rd] = 1'b1;
      for (int h = 0; h < `HART_NUM; h++)
         pending_nxt[h][0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int h = 0; h < `HART_NUM; h++)
            pending[h] <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end

   assign busy_rs1 = (chk_rs1 != '0) && pending[chk_hart_id][chk_rs1];
   assign busy_rs2 = (chk_rs2 != '0) && pending[chk_hart_id][chk_rs2];

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter: reset behaviour, ALU and LSU write
// latency, FIFO ordering and back-pressure, starvation forcing, scoreboard
// set/clear/priority, x0 handling and reset with a full queue.
`include "defines.vh"

module tb_wb_arbiter;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   alu_valid;
   logic                   alu_ready;
   logic [`HART_ID_W-1:0]  alu_hart_id;
   logic [`REG_ADDR_W-1:0] alu_rd;
   logic [`XLEN-1:0]       alu_wdata;
   logic                   lsu_valid;
   logic                   lsu_ready;
   logic [`HART_ID_W-1:0]  lsu_hart_id;
   logic [`REG_ADDR_W-1:0] lsu_rd;
   logic [`XLEN-1:0]       lsu_wdata;
   logic                   iss_en;
   logic [`HART_ID_W-1:0]  iss_hart_id;
   logic [`REG_ADDR_W-1:0] iss_rd;
   logic [`HART_ID_W-1:0]  chk_hart_id;
   logic [`REG_ADDR_W-1:0] chk_rs1;
   logic [`REG_ADDR_W-1:0] chk_rs2;
   logic                   busy_rs1;
   logic                   busy_rs2;
   logic                   w_en;
   logic [`HART_ID_W-1:0]  w_hart_id;
   logic [`REG_ADDR_W-1:0] waddr;
   logic [`XLEN-1:0]       wdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_arbiter #(.STARVE_MAX(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_hart_id(alu_hart_id),
      .alu_rd(alu_rd), .alu_wdata(alu_wdata),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_hart_id(lsu_hart_id),
      .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
      .iss_en(iss_en), .iss_hart_id(iss_hart_id), .iss_rd(iss_rd),
      .chk_hart_id(chk_hart_id), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
      .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
      .w_en(w_en), .w_hart_id(w_hart_id), .waddr(waddr), .wdata(wdata)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_vec++;
      assert (observed === expected)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance one clock; return 2 time units after the edge so registered
   // outputs have settled and the next drive is well away from the edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic alu(input logic v, input logic [`HART_ID_W-1:0] h,
                      input logic [`REG_ADDR_W-1:0] rd, input logic [`XLEN-1:0] d);
      alu_valid = v; alu_hart_id = h; alu_rd = rd; alu_wdata = d;
   endtask

   task automatic lsu(input logic v, input logic [`HART_ID_W-1:0] h,
                      input logic [`REG_ADDR_W-1:0] rd, input logic [`XLEN-1:0] d);
      lsu_valid = v; lsu_hart_id = h; lsu_rd = rd; lsu_wdata = d;
   endtask

   task automatic iss(input logic v, input logic [`HART_ID_W-1:0] h,
                      input logic [`REG_ADDR_W-1:0] rd);
      iss_en = v; iss_hart_id = h; iss_rd = rd;
   endtask

   task automatic chk(input logic [`HART_ID_W-1:0] h,
                      input logic [`REG_ADDR_W-1:0] r1, input logic [`REG_ADDR_W-1:0] r2);
      chk_hart_id = h; chk_rs1 = r1; chk_rs2 = r2;
      settle();
   endtask

   task automatic expect_write(input string tag, input logic [`HART_ID_W-1:0] h,
                               input logic [`REG_ADDR_W-1:0] rd, input logic [`XLEN-1:0] d);
      check({tag, ".w_en"},      32'(w_en), 32'd1);
      check({tag, ".w_hart_id"}, 32'(w_hart_id), 32'(h));
      check({tag, ".waddr"},     32'(waddr), 32'(rd));
      check({tag, ".wdata"},     wdata, d);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // ---- reset with all sources active: nothing may take effect ----
      rst_n = 1'b0;
      alu(1'b1, 1'b1, 5'd5, 32'h1111_1111);
      lsu(1'b1, 1'b0, 5'd3, 32'h2222_2222);
      iss(1'b1, 1'b0, 5'd9);
      chk(1'b0, 5'd9, 5'd0);
      repeat (3) cyc();
      check("rst.alu_ready", 32'(alu_ready), 32'd0);
      check("rst.lsu_ready", 32'(lsu_ready), 32'd0);
      check("rst.w_en",      32'(w_en), 32'd0);
      check("rst.w_hart_id", 32'(w_hart_id), 32'd0);
      check("rst.waddr",     32'(waddr), 32'd0);
      check("rst.wdata",     wdata, 32'd0);
      alu(1'b0, 1'b0, 5'd0, 32'd0);
      lsu(1'b0, 1'b0, 5'd0, 32'd0);
      iss(1'b0, 1'b0, 5'd0);
      rst_n = 1'b1;
      settle();
      check("rel.alu_ready", 32'(alu_ready), 32'd1);
      check("rel.lsu_ready", 32'(lsu_ready), 32'd1);
      check("rel.busy9",     32'(busy_rs1), 32'd0);
      cyc();
      check("rel.w_en", 32'(w_en), 32'd0);

      // ---- ALU only: one-cycle latency ----
      alu(1'b1, 1'b1, 5'd5, 32'hA5A5_A5A5);
      cyc();
      expect_write("alu", 1'b1, 5'd5, 32'hA5A5_A5A5);
      alu(1'b0, 1'b0, 5'd0, 32'd0);
      cyc();
      check("alu.idle", 32'(w_en), 32'd0);

      // ---- LSU order: push rd3 then rd4, no ALU ----
      lsu(1'b1, 1'b0, 5'd3, 32'h0000_0033);
      cyc();
      check("lsu.lat1", 32'(w_en), 32'd0);
      lsu(1'b1, 1'b0, 5'd4, 32'h0000_0044);
      settle();
      check("lsu.ready1", 32'(lsu_ready), 32'd1);
      cyc();
      expect_write("lsu.rd3", 1'b0, 5'd3, 32'h0000_0033);
      lsu(1'b0, 1'b0, 5'd0, 32'd0);
      cyc();
      expect_write("lsu.rd4", 1'b0, 5'd4, 32'h0000_0044);
      cyc();
      check("lsu.idle", 32'(w_en), 32'd0);

      // ---- starvation with a full queue and continuous ALU traffic ----
      alu(1'b1, 1'b0, 5'd10, 32'h0000_0100);
      lsu(1'b1, 1'b1, 5'd11, 32'h0000_00B1);
      cyc();                                   // ALU wins, rd11 queued
      expect_write("stv.e1", 1'b0, 5'd10, 32'h0000_0100);
      lsu(1'b1, 1'b1, 5'd12, 32'h0000_00C2);
      cyc();                                   // lost 1, rd12 queued -> full
      check("stv.full.lsu_ready", 32'(lsu_ready), 32'd0);
      check("stv.e2.waddr",       32'(waddr), 32'd10);
      lsu(1'b1, 1'b0, 5'd13, 32'h0000_00D3);   // must be refused while full
      settle();
      check("stv.e2.alu_ready", 32'(alu_ready), 32'd1);
      cyc();                                   // lost 2
      check("stv.e3.alu_ready", 32'(alu_ready), 32'd1);
      check("stv.e3.waddr",     32'(waddr), 32'd10);
      lsu(1'b0, 1'b0, 5'd0, 32'd0);
      cyc();                                   // lost 3 -> forced next
      check("stv.e4.alu_ready", 32'(alu_ready), 32'd0);
      check("stv.e4.waddr",     32'(waddr), 32'd10);
      cyc();                                   // forced pop of rd11
      expect_write("stv.force", 1'b1, 5'd11, 32'h0000_00B1);
      check("stv.e5.alu_ready", 32'(alu_ready), 32'd1);
      check("stv.e5.lsu_ready", 32'(lsu_ready), 32'd1);
      cyc();                                   // ALU wins again
      check("stv.e6.waddr", 32'(waddr), 32'd10);
      alu(1'b0, 1'b0, 5'd0, 32'd0);
      cyc();
      expect_write("stv.rd12", 1'b1, 5'd12, 32'h0000_00C2);
      cyc();
      check("stv.no_rd13", 32'(w_en), 32'd0);

      // ---- scoreboard set / per-hart / clear on LSU write ----
      iss(1'b1, 1'b0, 5'd7);
      cyc();
      iss(1'b0, 1'b0, 5'd0);
      chk(1'b0, 5'd7, 5'd7);
      check("sb.busy_rs1", 32'(busy_rs1), 32'd1);
      check("sb.busy_rs2", 32'(busy_rs2), 32'd1);
      chk(1'b1, 5'd7, 5'd7);
      check("sb.hart1_rs1", 32'(busy_rs1), 32'd0);
      check("sb.hart1_rs2", 32'(busy_rs2), 32'd0);
      chk(1'b0, 5'd7, 5'd0);
      lsu(1'b1, 1'b0, 5'd7, 32'h0000_0077);
      cyc();                                   // queued, not yet written
      lsu(1'b0, 1'b0, 5'd0, 32'd0);
      settle();
      check("sb.still_busy", 32'(busy_rs1), 32'd1);
      check("sb.w_en_pre",   32'(w_en), 32'd0);
      cyc();                                   // popped: write and clear together
      expect_write("sb.rd7", 1'b0, 5'd7, 32'h0000_0077);
      check("sb.cleared", 32'(busy_rs1), 32'd0);

      // ---- set wins over simultaneous clear; ALU never clears ----
      iss(1'b1, 1'b0, 5'd8);
      cyc();
      iss(1'b0, 1'b0, 5'd0);
      lsu(1'b1, 1'b0, 5'd8, 32'h0000_0088);
      cyc();
      lsu(1'b0, 1'b0, 5'd0, 32'd0);
      iss(1'b1, 1'b0, 5'd8);                   // re-issue in the retire cycle
      cyc();
      iss(1'b0, 1'b0, 5'd0);
      chk(1'b0, 5'd8, 5'd0);
      expect_write("sb.rd8", 1'b0, 5'd8, 32'h0000_0088);
      check("sb.set_wins", 32'(busy_rs1), 32'd1);
      alu(1'b1, 1'b0, 5'd8, 32'h0000_0808);
      cyc();
      alu(1'b0, 1'b0, 5'd0, 32'd0);
      settle();
      check("sb.alu_no_clear", 32'(busy_rs1), 32'd1);

      // ---- issue to x0 never becomes pending ----
      iss(1'b1, 1'b1, 5'd0);
      cyc();
      iss(1'b0, 1'b0, 5'd0);
      chk(1'b1, 5'd0, 5'd0);
      check("sb.x0_rs1", 32'(busy_rs1), 32'd0);
      check("sb.x0_rs2", 32'(busy_rs2), 32'd0);

      // ---- rd = 0 from both sources: consumed, no write ----
      alu(1'b1, 1'b1, 5'd0, 32'hDEAD_0001);
      lsu(1'b1, 1'b1, 5'd0, 32'hDEAD_0002);
      cyc();
      check("x0.alu_w_en", 32'(w_en), 32'd0);
      alu(1'b0, 1'b0, 5'd0, 32'd0);
      lsu(1'b0, 1'b0, 5'd0, 32'd0);
      cyc();
      check("x0.lsu_w_en", 32'(w_en), 32'd0);
      lsu(1'b1, 1'b1, 5'd20, 32'h0000_0020);
      cyc();
      lsu(1'b0, 1'b0, 5'd0, 32'd0);
      cyc();                                   // rd20 is head only if x0 entry left
      expect_write("x0.next", 1'b1, 5'd20, 32'h0000_0020);

      // ---- reset with two queued entries discards them ----
      alu(1'b1, 1'b0, 5'd1, 32'h0000_0001);
      lsu(1'b1, 1'b0, 5'd21, 32'h0000_0021);
      cyc();
      lsu(1'b1, 1'b0, 5'd22, 32'h0000_0022);
      cyc();
      check("rq.full", 32'(lsu_ready), 32'd0);
      alu(1'b0, 1'b0, 5'd0, 32'd0);
      lsu(1'b0, 1'b0, 5'd0, 32'd0);
      rst_n = 1'b0;
      cyc();
      check("rq.rst_w_en",  32'(w_en), 32'd0);
      check("rq.rst_waddr", 32'(waddr), 32'd0);
      rst_n = 1'b1;
      chk(1'b0, 5'd8, 5'd0);
      check("rq.pending_cleared", 32'(busy_rs1), 32'd0);
      check("rq.lsu_ready",       32'(lsu_ready), 32'd1);
      cyc();
      check("rq.post1_w_en", 32'(w_en), 32'd0);
      cyc();
      check("rq.post2_w_en", 32'(w_en), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3, meaning consecutive cycles a non-empty LSU queue may lose arbitration before forced priority.
REQ-002 SHALL have ports, one per line; all widths use `XLEN, `HART_ID_W and `REG_ADDR_W from defines.vh:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_hart_id  in  `HART_ID_W  ALU result hart.
- alu_rd  in  `REG_ADDR_W  ALU destination register.
- alu_wdata  in  `XLEN  ALU result data.
- lsu_valid  in  1  load/long-latency result present.
- lsu_ready  out  1  LSU queue can accept.
- lsu_hart_id  in  `HART_ID_W  LSU result hart.
- lsu_rd  in  `REG_ADDR_W  LSU destination register.
- lsu_wdata  in  `XLEN  LSU result data.
- iss_en  in  1  long-latency op issued; mark rd pending.
- iss_hart_id  in  `HART_ID_W  issuing hart.
- iss_rd  in  `REG_ADDR_W  register to mark pending.
- chk_hart_id  in  `HART_ID_W  hart being checked.
- chk_rs1  in  `REG_ADDR_W  first source to check.
- chk_rs2  in  `REG_ADDR_W  second source to check.
- busy_rs1  out  1  chk_rs1 pending, combinational.
- busy_rs2  out  1  chk_rs2 pending, combinational.
- w_en  out  1  register-file write enable, registered.
- w_hart_id  out  `HART_ID_W  write hart, registered.
- waddr  out  `REG_ADDR_W  write address, registered.
- wdata  out  `XLEN  write data, registered.

Function
REQ-003 LSU queue SHALL be a 2-entry FIFO; lsu_ready = (count != 2); push when lsu_valid && lsu_ready.
REQ-004 Force mode SHALL be active when starve counter == STARVE_MAX; alu_ready = !force.
REQ-005 Arbitration per cycle: if force and queue non-empty, pop head; else if alu_valid && alu_ready, take ALU; else if queue non-empty, pop head; else idle.
REQ-006 Selected entry SHALL appear on w_en/w_hart_id/waddr/wdata at the next rising edge (1-cycle latency); w_en = 1 only if the selected rd != 0.
REQ-007 Selected entries with rd == 0 SHALL be consumed (popped/accepted) with w_en = 0.
REQ-008 LSU result pushed into an empty queue at cycle N with no competing ALU SHALL produce w_en at N+2.
REQ-009 Push and pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-010 Starve counter SHALL increment when the queue is non-empty and not popped, saturate at STARVE_MAX, and clear on any pop or when the queue is empty.
REQ-011 Scoreboard SHALL hold one pending bit per hart per register; x0 SHALL never be pending.
REQ-012 iss_en with iss_rd != 0 SHALL set pending[iss_hart_id][iss_rd] at the next edge.
REQ-013 An LSU pop with rd != 0 SHALL clear the matching pending bit at the same edge that w_en asserts.
REQ-014 A simultaneous set and clear of the same bit SHALL leave it set.
REQ-015 ALU writes SHALL NOT modify the scoreboard.
REQ-016 busy_rsN = pending[chk_hart_id][chk_rsN]; busy_rsN = 0 when chk_rsN == 0.

Reset
REQ-017 While rst_n = 0 at a rising edge: w_en, w_hart_id, waddr and wdata SHALL be 0; FIFO empty; starve counter 0; all pending bits 0.
REQ-018 lsu_ready and alu_ready SHALL be 0 while rst_n = 0, and no push, pop or issue SHALL take effect.
REQ-019 Reset asserted mid-operation SHALL discard queued results without any write.

Structure
REQ-020 `HART_NUM, `HART_ID_W, `REG_ADDR_W and `XLEN SHALL come from defines.vh; no new shared constants are required.
REQ-021 The 2-entry queue SHALL be a sub-module wb_fifo2, with entry = {hart_id, rd, wdata}.

Verification
REQ-022 ALU-only: alu_valid, hart 1, rd 5, data 0xA5A5A5A5 at cycle N -> w_en = 1, w_hart_id = 1, waddr = 5, wdata = 0xA5A5A5A5 at N+1.
REQ-023 LSU order: two LSU pushes (rd 3, then rd 4) with no ALU -> writes rd 3 then rd 4 in consecutive cycles; lsu_ready = 0 only while count = 2.
REQ-024 Starvation: one queued LSU entry plus continuous alu_valid -> alu_ready = 0 after 3 lost cycles, LSU write occurs next, then alu_ready = 1.
REQ-025 Scoreboard: iss_en hart 0 rd 7 -> busy_rs1 = 1 for chk_rs1 = 7; an LSU result for rd 7 clears busy in the cycle w_en = 1; the same rd on hart 1 is never busy.
REQ-026 Edge cases: rd = 0 from both sources -> no w_en, both consumed; iss_rd = 0 -> busy = 0; reset with 2 queued entries -> no writes and count = 0.
